// File: rtl/pipe_delay_hs.sv
// pipe_delay_hs: fixed-latency delay pipeline with per-stage valid bits and a
// ready/valid handshake on both sides. Empty stages (bubbles) keep advancing
// while the output is stalled. The block also has a synchronous flush and an
// occupancy count.
module pipe_delay_hs #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 5,
    parameter int CW     = $clog2(CYCLES + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [CYCLES-1:0] v;
    logic [WIDTH-1:0]  d     [CYCLES];
    logic [CYCLES-1:0] en;
    logic [CYCLES-1:0] src_v;
    logic [WIDTH-1:0]  src_d [CYCLES];
    logic [CW-1:0]     count;
    logic              accept;
    logic              emit;

    // Stage enables: a stage may load when it or any stage ahead of it is
    // empty, or when the output beat is being taken. The chain is walked
    // back from the output with a running term so that no bit of en is
    // computed from another bit of en.
    always_comb begin
        logic run;
        en  = '0;
        run = i_ready;
        for (int k = CYCLES - 1; k >= 0; k--) begin
            run   = run | !v[k];
            en[k] = run;
        end
    end

    assign o_ready = en[0] & !i_flush & !i_reset;
    assign accept  = i_valid & o_ready;
    assign o_valid = v[CYCLES-1];
    assign o_data  = d[CYCLES-1];
    assign emit    = o_valid & i_ready;
    assign o_count = count;

    // Source of each stage: the previous stage, or the accepted input beat
    // for stage 0.
    always_comb begin
        src_v[0] = accept;
        src_d[0] = i_data;
        for (int k = 1; k < CYCLES; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = d[k-1];
        end
    end

    // Valid bits: cleared by reset or flush, otherwise advance where enabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v <= '0;
        end else if (i_flush) begin
            v <= '0;
        end else begin
            for (int k = 0; k < CYCLES; k++) begin
                if (en[k]) begin
                    v[k] <= src_v[k];
                end
            end
        end
    end

    // Payload: only loaded when a valid beat moves in, so bubbles leave
    // stale data in place. Flush does not touch the payload.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < CYCLES; k++) begin
                d[k] <= '0;
            end
        end else if (!i_flush) begin
            for (int k = 0; k < CYCLES; k++) begin
                if (en[k] && src_v[k]) begin
                    d[k] <= src_d[k];
                end
            end
        end
    end

    // Occupancy: +1 per accepted beat, -1 per delivered beat; never
    // overflows because o_ready drops once every stage holds a beat.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(accept) - CW'(emit);
        end
    end

endmodule

// File: tb/tb_pipe_delay_hs.sv
// Directed testbench for pipe_delay_hs with WIDTH = 8, CYCLES = 5.
module tb_pipe_delay_hs;

    localparam int WIDTH  = 8;
    localparam int CYCLES = 5;
    localparam int CW     = $clog2(CYCLES + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] send_q[$];
    logic [WIDTH-1:0] exp_q[$];

    pipe_delay_hs #(.WIDTH(WIDTH), .CYCLES(CYCLES)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_data  (in_data),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_data  (out_data),
        .o_count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles sending send_q and matching every emitted beat to exp_q.
    task automatic drain(input string tag, input int n);
        logic acc;
        for (int c = 0; c < n; c++) begin
            in_valid = (send_q.size() > 0);
            in_data  = (send_q.size() > 0) ? send_q[0] : '0;
            #1;
            acc = in_valid & out_ready;
            if (out_valid && in_ready) begin
                if (exp_q.size() > 0) begin
                    check({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                end else begin
                    check({tag, "_extra"}, 32'(out_valid), 32'd0);
                end
            end
            tick();
            if (acc) void'(send_q.pop_front());
        end
        in_valid = 1'b0;
        check({tag, "_left_exp"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_left_send"}, 32'(send_q.size()), 32'd0);
        #1;
        check({tag, "_cnt_end"}, 32'(count), 32'd0);
        #0;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_ready = 1'b1;

        // Reset held while upstream offers a beat
        tick();
        tick();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_release_ready", 32'(out_ready), 32'd1);
        tick();

        // Streaming 1..20 with i_ready = 1
        in_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            in_valid = (c < 20);
            in_data  = WIDTH'(c + 1);
            #1;
            if (c < 20) check("stream_ready", 32'(out_ready), 32'd1);
            if (c < 5 || c >= 25) begin
                check("stream_idle_valid", 32'(out_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(c - 4));
            end
            if (c >= 5 && c < 20) check("stream_count", 32'(count), 32'd5);
            tick();
        end
        in_valid = 1'b0;

        // Full stall: push 1..7 with i_ready = 0
        in_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(c + 1);
            #1;
            check("full_ready", 32'(out_ready), (c < 5) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", 32'(count), 32'd5);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_data", 32'(out_data), 32'd1);
        check("full_ready_idle", 32'(out_ready), 32'd0);
        tick();
        in_ready = 1'b1;
        send_q = '{8'd6, 8'd7};
        exp_q  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        drain("full", 14);

        // Bubble collapse: 1,2,3 on alternate cycles, then 4,5 back-to-back
        in_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0) || (c == 2) || (c >= 4);
            in_data  = (c < 4) ? WIDTH'(c / 2 + 1) : WIDTH'(c - 1);
            #1;
            if (in_valid) check("bubble_ready", 32'(out_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bubble_count", 32'(count), 32'd5);
        check("bubble_full", 32'(out_ready), 32'd0);
        tick();
        in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bubble_out_valid", 32'(out_valid), 32'd1);
            check("bubble_out_data", 32'(out_data), 32'(i + 1));
            tick();
        end
        #1;
        check("bubble_empty_valid", 32'(out_valid), 32'd0);
        check("bubble_empty_count", 32'(count), 32'd0);
        tick();

        // Flush with three beats in flight
        in_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(11 + c);
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd9;
        #1;
        check("flush_ready", 32'(out_ready), 32'd0);
        check("flush_count_before", 32'(count), 32'd3);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        tick();
        send_q = '{8'd21, 8'd22};
        exp_q  = '{8'd21, 8'd22};
        drain("post_flush", 12);

        // Asynchronous reset between edges during streaming
        in_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(40 + c);
            tick();
        end
        #1;
        check("pre_areset_count", 32'(count), 32'd5);
        check("pre_areset_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_count", 32'(count), 32'd0);
        check("areset_data", 32'(out_data), 32'd0);
        check("areset_ready", 32'(out_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        #3;
        rst = 1'b0;
        tick();
        send_q = '{8'd31, 8'd32, 8'd33};
        exp_q  = '{8'd31, 8'd32, 8'd33};
        drain("restart", 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
